// File: rtl/trng_pkg.sv
// Shared types, default tap tables and sizing helpers for the ring-generator TRNG.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } trng_state_e;

  localparam int TAP_NUM = 5;
  typedef int tap_tbl_t [TAP_NUM];

  // Feedback pairs for the default 256-bit ring: next R[dst] also takes R[src].
  localparam tap_tbl_t TAP_DST_DEF = '{20, 42, 62, 83, 105};
  localparam tap_tbl_t TAP_SRC_DEF = '{235, 213, 192, 171, 150};

  // Bits needed to hold the values 0 .. n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test: raises a sticky alarm once the same word
// has been captured REP_LIMIT times in a row.
module trng_rep_test
  import trng_pkg::*;
#(
  parameter int OUT_W     = 32,
  parameter int REP_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_sample,
  input  logic [OUT_W-1:0] i_word,
  output logic             o_alarm
);

  localparam int               CNT_W     = cnt_width(REP_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(REP_LIMIT);

  logic [OUT_W-1:0] r_prev;
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_alarm;
  logic             w_repeat;
  logic [CNT_W-1:0] w_cnt_next;

  // A zero count means no word has been seen since reset, so nothing to compare against.
  always_comb begin
    w_repeat   = (r_rep_cnt != '0) && (i_word == r_prev);
    w_cnt_next = CNT_W'(1);
    if (w_repeat) begin
      w_cnt_next = (r_rep_cnt >= CNT_LIMIT) ? CNT_LIMIT : r_rep_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev    <= '0;
      r_rep_cnt <= '0;
      r_alarm   <= 1'b0;
    end else if (i_sample) begin
      r_prev    <= i_word;
      r_rep_cnt <= w_cnt_next;
      if (w_cnt_next >= CNT_LIMIT) begin
        r_alarm <= 1'b1;
      end
    end
  end

  assign o_alarm = r_alarm;

endmodule

// File: rtl/trng_ring_gen.sv
// Ring-generator TRNG core: a rotating register with XOR feedback taps and
// synchronized oscillator injection, decimated into a valid/ready word stream.
module trng_ring_gen
  import trng_pkg::*;
#(
  parameter int               WIDTH            = 256,
  parameter int               INJ              = 11,
  parameter int               OUT_W            = 32,
  parameter int               WARMUP           = 512,
  parameter int               DECIM            = 64,
  parameter int               REP_LIMIT        = 8,
  parameter int               NTAPS            = TAP_NUM,
  parameter int               TAP_DST [NTAPS]  = TAP_DST_DEF,
  parameter int               TAP_SRC [NTAPS]  = TAP_SRC_DEF,
  parameter logic [WIDTH-1:0] SEED_INIT        = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             inj_en,
  input  logic [INJ-1:0]   injector,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             alarm,
  output logic [15:0]      drop_cnt
);

  localparam int               WU_W     = cnt_width(WARMUP);
  localparam int               DEC_W    = cnt_width(DECIM);
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

  trng_state_e      r_state;
  trng_state_e      w_state_next;
  logic [WIDTH-1:0] r_ring;
  logic [WIDTH-1:0] w_ring_next;
  logic [INJ-1:0]   r_inj_meta;
  logic [INJ-1:0]   r_inj_sync;
  logic [WU_W-1:0]  r_wu_cnt;
  logic [DEC_W-1:0] r_dec_cnt;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic [15:0]      r_drop_cnt;
  logic             w_wu_done;
  logic             w_in_warmup;
  logic             w_stay_run;
  logic             w_sample;
  logic             w_alarm;

  // NOTE: non-blocking so the second stage takes the first stage's pre-edge
  // value; blocking here would collapse the synchronizer into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inj_meta <= '0;
      r_inj_sync <= '0;
    end else begin
      r_inj_meta <= injector;
      r_inj_sync <= r_inj_meta;
    end
  end

  // NOTE: full default first, so no path through this block can infer a latch.
  always_comb begin
    w_ring_next = {r_ring[0], r_ring[WIDTH-1:1]};
    for (int t = 0; t < NTAPS; t++) begin
      w_ring_next[TAP_DST[t]] = w_ring_next[TAP_DST[t]] ^ r_ring[TAP_SRC[t]];
    end
    if (inj_en) begin
      for (int k = 0; k < INJ; k++) begin
        w_ring_next[WIDTH-2-k] = w_ring_next[WIDTH-2-k] ^ r_inj_sync[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ring <= SEED_INIT;
    end else if (seed_load) begin
      r_ring <= seed;
    end else if (enable) begin
      r_ring <= w_ring_next;
    end
  end

  assign w_wu_done = (r_state == ST_WARMUP) && (r_wu_cnt == WU_LAST);

  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = ST_IDLE;
    end else if (seed_load) begin
      w_state_next = ST_WARMUP;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_next = ST_WARMUP;
        ST_WARMUP: if (w_wu_done) w_state_next = ST_RUN;
        ST_RUN:    w_state_next = ST_RUN;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counters run only while the state is held; any transition or reseed clears them.
  assign w_in_warmup = (r_state == ST_WARMUP) && (w_state_next == ST_WARMUP) && !seed_load;
  assign w_stay_run  = (r_state == ST_RUN) && (w_state_next == ST_RUN);
  assign w_sample    = w_stay_run && (r_dec_cnt == DEC_LAST) && !w_alarm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wu_cnt <= '0;
    end else if (w_in_warmup) begin
      r_wu_cnt <= r_wu_cnt + WU_W'(1);
    end else begin
      r_wu_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_cnt <= '0;
    end else if (!w_stay_run || (r_dec_cnt == DEC_LAST)) begin
      r_dec_cnt <= '0;
    end else begin
      r_dec_cnt <= r_dec_cnt + DEC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_drop_cnt  <= '0;
    end else if (!w_stay_run || w_alarm) begin
      r_out_valid <= 1'b0;
    end else if (w_sample) begin
      if (!r_out_valid || out_ready) begin
        r_out_data  <= r_ring[OUT_W-1:0];
        r_out_valid <= 1'b1;
      end else if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  trng_rep_test #(
    .OUT_W     (OUT_W),
    .REP_LIMIT (REP_LIMIT)
  ) u_rep_test (
    .clk      (clk),
    .reset    (reset),
    .i_sample (w_sample),
    .i_word   (r_ring[OUT_W-1:0]),
    .o_alarm  (w_alarm)
  );

  // Gating with the alarm hides the word captured on the very edge the alarm trips.
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid && !w_alarm;
  assign alarm     = w_alarm;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_trng_ring_gen.sv
// Directed bench for trng_ring_gen with short warm-up/decimation settings and a
// bit-level software model of the deterministic ring.
module tb_trng_ring_gen;
  import trng_pkg::*;

  localparam int W     = 256;
  localparam int INJ_N = 11;
  localparam int OW    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             inj_en;
  logic [INJ_N-1:0] injector;
  logic             seed_load;
  logic [W-1:0]     seed;
  logic [OW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             alarm;
  logic [15:0]      drop_cnt;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_ring;
  int           tap_dst [5] = '{20, 42, 62, 83, 105};
  int           tap_src [5] = '{235, 213, 192, 171, 150};

  trng_ring_gen #(
    .WIDTH     (W),
    .INJ       (INJ_N),
    .OUT_W     (OW),
    .WARMUP    (4),
    .DECIM     (8),
    .REP_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .inj_en    (inj_en),
    .injector  (injector),
    .seed_load (seed_load),
    .seed      (seed),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alarm     (alarm),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Golden deterministic ring: rotate toward bit 0, then apply the feedback pairs.
  function automatic logic [W-1:0] model_shift(input logic [W-1:0] cur);
    logic [W-1:0] nxt;
    for (int i = 0; i < W; i++) nxt[i] = cur[(i + 1) % W];
    for (int t = 0; t < 5; t++) nxt[tap_dst[t]] = nxt[tap_dst[t]] ^ cur[tap_src[t]];
    return nxt;
  endfunction

  // One clock edge; the model follows the same priority as the inputs at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset)          m_ring = W'(1);
    else if (seed_load) m_ring = seed;
    else if (enable)    m_ring = model_shift(m_ring);
    #1;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_valid"}, W'(out_valid), W'(0));
    check({pfx, "_data"},  W'(out_data),  W'(0));
    check({pfx, "_alarm"}, W'(alarm),     W'(0));
    check({pfx, "_drop"},  W'(drop_cnt),  W'(0));
    check({pfx, "_state"}, W'(dut.r_state), W'(ST_IDLE));
    check({pfx, "_ring"},  dut.r_ring,    W'(1));
  endtask

  initial begin
    int           first;
    int           got;
    int           seen;
    logic [W-1:0] bit254;
    logic [W-1:0] a5_seed;

    reset = 1'b1; enable = 1'b0; inj_en = 1'b0; injector = '0;
    seed_load = 1'b0; seed = '0; out_ready = 1'b0;
    m_ring = W'(1);
    tick(); tick();
    check_reset_state("rst");

    // Seed 1, deterministic: first word after 12 shifts has no bits in [31:0].
    reset = 1'b0; enable = 1'b1;
    first = -1;
    for (int e = 1; e <= 30 && first < 0; e++) begin
      tick();
      if (out_valid === 1'b1) first = e;
    end
    check("first_valid_edge", W'(first), W'(13));
    check("first_word", W'(out_data), W'(32'h0));
    check("ring_vs_model_13", dut.r_ring, m_ring);
    check("state_run", W'(dut.r_state), W'(ST_RUN));

    // Two more sample events with out_ready low: both dropped, first word kept.
    repeat (8) tick();
    check("drop_after_2nd", W'(drop_cnt), W'(1));
    repeat (8) tick();
    check("drop_after_3rd", W'(drop_cnt), W'(2));
    check("kept_first_word", W'(out_data), W'(32'h0));
    check("valid_held", W'(out_valid), W'(1));
    check("ring_vs_model_29", dut.r_ring, m_ring);
    check("no_alarm_b", W'(alarm), W'(0));

    // Handshake clears valid; the next sample (36 shifts) lands with bit 6 set.
    out_ready = 1'b1;
    tick();
    check("valid_cleared_by_ready", W'(out_valid), W'(0));
    repeat (7) tick();
    check("word_36_shifts", W'(out_data), W'(32'h40));
    check("valid_4th", W'(out_valid), W'(1));

    // Reseed mid-RUN while a word is pending.
    a5_seed = {32{8'hA5}};
    out_ready = 1'b0; seed_load = 1'b1; seed = a5_seed;
    tick();
    seed_load = 1'b0;
    check("seed_ring", dut.r_ring, a5_seed);
    check("seed_state", W'(dut.r_state), W'(ST_WARMUP));
    check("seed_valid", W'(out_valid), W'(0));
    repeat (4) tick();
    check("seed_run_again", W'(dut.r_state), W'(ST_RUN));
    check("seed_ring_vs_model", dut.r_ring, m_ring);

    // Injector 0 goes high: two synchronizer edges, then R[254] flips on the third.
    inj_en = 1'b1; injector = INJ_N'(1);
    tick(); tick();
    check("inj_no_div_yet", dut.r_ring, m_ring);
    tick();
    bit254 = '0; bit254[254] = 1'b1;
    check("inj_div_bit254", dut.r_ring ^ m_ring, bit254);
    repeat (5) tick();
    injector = '0; inj_en = 1'b0;

    // Reset while a word is pending; enable and seed_load held to prove priority.
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      tick();
      if (out_valid === 1'b1) got = 1;
    end
    check("valid_before_reset", W'(got), W'(1));
    reset = 1'b1; seed_load = 1'b1;
    tick();
    check_reset_state("midrun_rst");
    reset = 1'b0; seed_load = 1'b0; enable = 1'b0;
    tick();

    // All-zero seed: four identical captured words trip the alarm.
    enable = 1'b1; seed_load = 1'b1; seed = '0; out_ready = 1'b1;
    tick();
    seed_load = 1'b0;
    repeat (12) tick();
    check("zero_word1_valid", W'(out_valid), W'(1));
    check("zero_word1_data", W'(out_data), W'(0));
    repeat (16) tick();
    check("alarm_low_after_3", W'(alarm), W'(0));
    repeat (8) tick();
    check("alarm_after_4", W'(alarm), W'(1));
    check("valid_low_on_alarm", W'(out_valid), W'(0));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    check("valid_stays_low", W'(seen), W'(0));
    check("alarm_sticky", W'(alarm), W'(1));
    check("alarm_state_run", W'(dut.r_state), W'(ST_RUN));
    check("alarm_no_drop", W'(drop_cnt), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_ring_gen.md
TRNG_RING_GEN -- requirements
Module: trng_ring_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 256: ring-generator register length; 32 to 1024.
REQ-002 SHALL have parameter INJ, default 11: injector input count; 1 to WIDTH-2.
REQ-003 SHALL have parameter OUT_W, default 32: output word width; at most WIDTH.
REQ-004 SHALL have parameters WARMUP (default 512), DECIM (default 64) and REP_LIMIT (default 8), all cycle or sample counts of at least 1.
REQ-005 SHALL have parameters NTAPS, TAP_DST and TAP_SRC, with defaults from trng_pkg: feedback tap pairs.
REQ-006 SHALL have parameter SEED_INIT, default 1: register reset value.
REQ-007 SHALL have ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  run the generator.
- inj_en  in  1  1 = XOR injectors in; 0 = deterministic mode.
- injector  in  INJ  asynchronous ring-oscillator taps.
- seed_load  in  1  load-seed pulse.
- seed  in  WIDTH  seed value.
- out_data  out  OUT_W  sampled word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word.
- alarm  out  1  repetition failure, sticky.
- drop_cnt  out  16  words dropped, saturating.

Function
REQ-008 SHALL pass each injector bit through a 2-flop synchronizer before use.
REQ-009 SHALL, on each enabled shift, set R[i] <= R[i+1] for i < WIDTH-1 and R[WIDTH-1] <= R[0].
REQ-010 SHALL additionally XOR R[TAP_SRC[t]] into the next value of R[TAP_DST[t]] for each tap t.
REQ-011 SHALL, when inj_en=1, XOR synchronized injector[k] into the next value of R[WIDTH-2-k].
REQ-012 SHALL hold R unchanged whenever enable=0.
REQ-013 SHALL implement states IDLE, WARMUP and RUN:
- IDLE->WARMUP on enable=1.
- WARMUP->RUN after WARMUP shifts.
- any state->IDLE on enable=0.
REQ-014 SHALL give seed_load priority over shifting: R <= seed that edge, in any state.
REQ-015 SHALL, on seed_load with enable=1, go to WARMUP and clear the warm-up and decimation counters.
REQ-016 SHALL, in RUN, raise a sample event every DECIM cycles, when the decimation counter equals DECIM-1.
REQ-017 SHALL have the sample event capture pre-edge R[OUT_W-1:0].
REQ-018 SHALL set out_valid on the edge after a sample event and hold it until an out_valid & out_ready edge.
REQ-019 SHALL, on a sample event while out_valid=1 and out_ready=0, discard the new word, keep out_data, and increment drop_cnt (saturating at 0xFFFF).
REQ-020 SHALL, on a sample event coinciding with out_ready=1, replace the word and keep out_valid=1, with no drop counted.
REQ-021 SHALL run a repetition test on captured words:
- rep_cnt increments when a word equals the previous word, else reloads 1.
- alarm sets when rep_cnt reaches REP_LIMIT.
REQ-022 SHALL, while alarm=1, force out_valid=0 and suppress sample events, with shifting continuing.
REQ-023 SHALL clear out_valid and the decimation counter on any exit from RUN.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, set:
- R = SEED_INIT, state IDLE, all counters 0;
- out_data=0, out_valid=0, alarm=0, drop_cnt=0, synchronizers 0.
REQ-025 SHALL give reset priority over seed_load and enable, including when reset arrives mid-RUN.

Structure
REQ-026 SHALL place in a shared package trng_pkg:
- the state enumeration;
- the default WIDTH=256 tap tables (dst/src): 20/235, 42/213, 62/192, 83/171, 105/150.
REQ-027 SHALL implement the repetition test as sub-module trng_rep_test.
REQ-028 SHALL keep the ring oscillator outside this module.

Verification (WIDTH=256, INJ=11, OUT_W=32, WARMUP=4, DECIM=8, REP_LIMIT=4)
REQ-029 SHALL cover: reset; enable=1, inj_en=0, seed 1 -> out_valid first high 13 edges after enable, out_data matching the software golden model.
REQ-030 SHALL cover: out_ready=0 across 3 sample events -> drop_cnt=2 and out_data equal to the first word.
REQ-031 SHALL cover: seed_load with seed=0, inj_en=0 -> alarm=1 after the 4th captured word, with out_valid=0 thereafter.
REQ-032 SHALL cover: seed_load mid-RUN with seed=0xA5 repeated -> next-edge R=seed, state WARMUP, out_valid=0.
REQ-033 SHALL cover: injector[0] held high for one RUN window, inj_en=1 -> divergence from the model first at R[254], 3 edges after the toggle.
REQ-034 SHALL cover: reset mid-RUN with out_valid=1 -> all outputs at reset values on the next edge.
